// File: rtl/segre_store_buffer.sv
// ============================================================================
// Module   : segre_store_buffer
// Purpose  : In-order buffer of committed stores. It forwards data to loads
//            and drains its oldest entry to the data cache.
// Revision : 1.0
// ============================================================================
`default_nettype none

module segre_store_buffer #(
    parameter int NUM_ELEMS = 2,
    parameter int ADDR_SIZE = 32,
    parameter int WORD_SIZE = 32
) (
    input  logic                 clk_i,
    input  logic                 rsn_i,
    input  logic                 req_store_i,
    input  logic                 req_load_i,
    input  logic                 flush_chance_i,
    input  logic [ADDR_SIZE-1:0] addr_i,
    input  logic [WORD_SIZE-1:0] data_i,
    input  logic [1:0]           memop_data_type_i,
    output logic                 hit_o,
    output logic                 miss_o,
    output logic                 full_o,
    output logic                 data_valid_o,
    output logic                 trouble_o,
    output logic [1:0]           memop_data_type_o,
    output logic [WORD_SIZE-1:0] data_load_o,
    output logic [WORD_SIZE-1:0] data_flush_o,
    output logic [ADDR_SIZE-1:0] addr_o
);

    localparam int PTR_W = (NUM_ELEMS > 1) ? $clog2(NUM_ELEMS) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] C_NUM_ELEMS = CNT_W'(NUM_ELEMS);

    logic [NUM_ELEMS-1:0] r_valid;
    logic [ADDR_SIZE-1:0] r_addr [NUM_ELEMS];
    logic [WORD_SIZE-1:0] r_data [NUM_ELEMS];
    logic [1:0]           r_type [NUM_ELEMS];
    logic [PTR_W-1:0]     r_head;
    logic [PTR_W-1:0]     r_tail;
    logic [CNT_W-1:0]     r_count;

    logic [PTR_W-1:0] w_age_idx [NUM_ELEMS];
    logic             w_empty;
    logic             w_pop;
    logic             w_merge;
    logic [PTR_W-1:0] w_merge_idx;
    logic             w_ovl;
    logic [PTR_W-1:0] w_ovl_idx;
    logic             w_exact;
    logic             w_load;
    logic             w_alloc;
    logic             w_drop;

    // w_age_idx[k] is the slot holding the k-th oldest entry.
    for (genvar k = 0; k < NUM_ELEMS; k++) begin : g_age
        assign w_age_idx[k] = r_head + PTR_W'(k);
    end

    assign w_empty      = (r_count == '0);
    assign data_valid_o = !w_empty;
    assign full_o       = (r_count == C_NUM_ELEMS);
    assign w_pop        = flush_chance_i && !w_empty;

    // Oldest to youngest scan, so the last match is the youngest one.
    always_comb begin
        w_merge     = 1'b0;
        w_merge_idx = '0;
        w_ovl       = 1'b0;
        w_ovl_idx   = '0;
        for (int k = 0; k < NUM_ELEMS; k++) begin
            if (r_valid[w_age_idx[k]]) begin
                if (r_addr[w_age_idx[k]][ADDR_SIZE-1:2] == addr_i[ADDR_SIZE-1:2]) begin
                    w_ovl     = 1'b1;
                    w_ovl_idx = w_age_idx[k];
                end
                if ((r_addr[w_age_idx[k]] == addr_i) &&
                    (r_type[w_age_idx[k]] == memop_data_type_i) &&
                    !(w_pop && (w_age_idx[k] == r_head))) begin
                    w_merge     = 1'b1;
                    w_merge_idx = w_age_idx[k];
                end
            end
        end
    end

    assign w_exact = (r_addr[w_ovl_idx] == addr_i) && (r_type[w_ovl_idx] == memop_data_type_i);
    assign w_load  = req_load_i && !req_store_i;
    assign w_alloc = req_store_i && !w_merge && (!full_o || w_pop);
    assign w_drop  = req_store_i && !w_merge && full_o && !w_pop;

    assign hit_o       = w_load && w_ovl && w_exact;
    assign miss_o      = w_load && !w_ovl;
    assign trouble_o   = w_drop || (w_load && w_ovl && !w_exact);
    assign data_load_o = hit_o ? r_data[w_ovl_idx] : '0;

    assign addr_o            = w_empty ? '0 : r_addr[r_head];
    assign data_flush_o      = w_empty ? '0 : r_data[r_head];
    assign memop_data_type_o = w_empty ? '0 : r_type[r_head];

    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            r_valid <= '0;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            for (int i = 0; i < NUM_ELEMS; i++) begin
                r_addr[i] <= '0;
                r_data[i] <= '0;
                r_type[i] <= '0;
            end
        end else begin
            if (w_pop) begin
                r_valid[r_head] <= 1'b0;
                r_head          <= r_head + 1'b1;
            end
            if (req_store_i && w_merge) begin
                r_data[w_merge_idx] <= data_i;
            end
            // When full with a pop, tail equals head; this later write wins.
            if (w_alloc) begin
                r_valid[r_tail] <= 1'b1;
                r_addr[r_tail]  <= addr_i;
                r_data[r_tail]  <= data_i;
                r_type[r_tail]  <= memop_data_type_i;
                r_tail          <= r_tail + 1'b1;
            end
            case ({w_alloc, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_segre_store_buffer.sv
// ============================================================================
// Module   : tb_segre_store_buffer
// Purpose  : Vector table plus scoreboard of drained stores for the buffer.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_segre_store_buffer;

    localparam int NUM_ELEMS = 2;
    localparam logic [1:0] C_BYTE = 2'd0;
    localparam logic [1:0] C_HALF = 2'd1;
    localparam logic [1:0] C_WORD = 2'd2;

    logic        clk_i = 1'b0;
    logic        rsn_i = 1'b0;
    logic        req_store_i = 1'b0;
    logic        req_load_i = 1'b0;
    logic        flush_chance_i = 1'b0;
    logic [31:0] addr_i = '0;
    logic [31:0] data_i = '0;
    logic [1:0]  memop_data_type_i = '0;
    logic        hit_o, miss_o, full_o, data_valid_o, trouble_o;
    logic [1:0]  memop_data_type_o;
    logic [31:0] data_load_o, data_flush_o, addr_o;

    segre_store_buffer #(.NUM_ELEMS(NUM_ELEMS), .ADDR_SIZE(32), .WORD_SIZE(32)) dut (
        .clk_i             (clk_i),
        .rsn_i             (rsn_i),
        .req_store_i       (req_store_i),
        .req_load_i        (req_load_i),
        .flush_chance_i    (flush_chance_i),
        .addr_i            (addr_i),
        .data_i            (data_i),
        .memop_data_type_i (memop_data_type_i),
        .hit_o             (hit_o),
        .miss_o            (miss_o),
        .full_o            (full_o),
        .data_valid_o      (data_valid_o),
        .trouble_o         (trouble_o),
        .memop_data_type_o (memop_data_type_o),
        .data_load_o       (data_load_o),
        .data_flush_o      (data_flush_o),
        .addr_o            (addr_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        st, ld, fl;
        logic [31:0] addr, data;
        logic [1:0]  ty;
        logic        hit, miss, trb;
        logic [31:0] dl;
    } vec_t;

    typedef struct {
        logic [31:0] addr, data;
        logic [1:0]  ty;
    } entry_t;

    vec_t   vecs[$];
    entry_t sb[$];
    int     n_checks = 0;
    int     n_pass = 0;

    function automatic vec_t mk(logic st, logic ld, logic fl, logic [31:0] addr,
                                logic [31:0] data, logic [1:0] ty, logic hit,
                                logic miss, logic trb, logic [31:0] dl);
        vec_t v;
        v.st = st; v.ld = ld; v.fl = fl; v.addr = addr; v.data = data; v.ty = ty;
        v.hit = hit; v.miss = miss; v.trb = trb; v.dl = dl;
        return v;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Head/empty/full checks against the scoreboard, then advance it by one edge.
    task automatic model_step(vec_t v);
        bit pop;
        int merge_j;
        pop = v.fl && (sb.size() != 0);
        check("data_valid", 32'(data_valid_o), 32'(sb.size() != 0));
        check("full", 32'(full_o), 32'(sb.size() == NUM_ELEMS));
        if (sb.size() == 0) begin
            check("addr_o_empty", addr_o, 32'h0);
            check("flush_data_empty", data_flush_o, 32'h0);
        end else if (pop) begin
            check("flush_addr", addr_o, sb[0].addr);
            check("flush_data", data_flush_o, sb[0].data);
            check("flush_type", 32'(memop_data_type_o), 32'(sb[0].ty));
        end
        merge_j = -1;
        if (v.st) begin
            for (int j = (pop ? 1 : 0); j < sb.size(); j++)
                if (sb[j].addr == v.addr && sb[j].ty == v.ty) merge_j = j;
            if (merge_j >= 0) sb[merge_j].data = v.data;
        end
        if (pop) void'(sb.pop_front());
        if (v.st && merge_j < 0 && (sb.size() < NUM_ELEMS)) begin
            entry_t e;
            e.addr = v.addr; e.data = v.data; e.ty = v.ty;
            if (!(sb.size() == NUM_ELEMS - 1 && !pop && (sb.size() + 1 > NUM_ELEMS)))
                sb.push_back(e);
        end
    endtask

    task automatic apply(vec_t v, int idx);
        @(negedge clk_i);
        req_store_i = v.st; req_load_i = v.ld; flush_chance_i = v.fl;
        addr_i = v.addr; data_i = v.data; memop_data_type_i = v.ty;
        #1;
        check($sformatf("hit[%0d]", idx), 32'(hit_o), 32'(v.hit));
        check($sformatf("miss[%0d]", idx), 32'(miss_o), 32'(v.miss));
        check($sformatf("trouble[%0d]", idx), 32'(trouble_o), 32'(v.trb));
        check($sformatf("data_load[%0d]", idx), data_load_o, v.dl);
        model_step(v);
        @(posedge clk_i);
    endtask

    initial begin
        //                st ld fl addr          data          type    hit miss trb data_load
        vecs.push_back(mk(0, 0, 0, 32'h0,        32'h0,        C_WORD, 0, 0, 0, 32'h0));
        vecs.push_back(mk(1, 0, 0, 32'h100,      32'hDEADBEEF, C_WORD, 0, 0, 0, 32'h0));
        vecs.push_back(mk(0, 1, 0, 32'h100,      32'h0,        C_WORD, 1, 0, 0, 32'hDEADBEEF));
        vecs.push_back(mk(0, 1, 0, 32'h200,      32'h0,        C_WORD, 0, 1, 0, 32'h0));
        vecs.push_back(mk(1, 0, 0, 32'h101,      32'hAA,       C_BYTE, 0, 0, 0, 32'h0));
        vecs.push_back(mk(0, 1, 0, 32'h100,      32'h0,        C_WORD, 0, 0, 1, 32'h0));
        vecs.push_back(mk(0, 1, 0, 32'h101,      32'h0,        C_BYTE, 1, 0, 0, 32'hAA));
        vecs.push_back(mk(1, 1, 0, 32'h300,      32'h5,        C_WORD, 0, 0, 1, 32'h0));
        vecs.push_back(mk(0, 0, 1, 32'h0,        32'h0,        C_WORD, 0, 0, 0, 32'h0));
        vecs.push_back(mk(0, 1, 1, 32'h100,      32'h0,        C_WORD, 0, 0, 1, 32'h0));
        vecs.push_back(mk(1, 0, 0, 32'h10,       32'h1,        C_WORD, 0, 0, 0, 32'h0));
        vecs.push_back(mk(1, 0, 0, 32'h20,       32'h2,        C_WORD, 0, 0, 0, 32'h0));
        vecs.push_back(mk(1, 0, 0, 32'h30,       32'h3,        C_WORD, 0, 0, 1, 32'h0));
        vecs.push_back(mk(1, 0, 1, 32'h30,       32'h3,        C_WORD, 0, 0, 0, 32'h0));
        vecs.push_back(mk(0, 1, 1, 32'h20,       32'h0,        C_WORD, 1, 0, 0, 32'h2));
        vecs.push_back(mk(0, 0, 1, 32'h0,        32'h0,        C_WORD, 0, 0, 0, 32'h0));
        vecs.push_back(mk(1, 0, 0, 32'h40,       32'h1,        C_WORD, 0, 0, 0, 32'h0));
        vecs.push_back(mk(1, 0, 0, 32'h40,       32'h2,        C_WORD, 0, 0, 0, 32'h0));
        vecs.push_back(mk(0, 0, 1, 32'h0,        32'h0,        C_WORD, 0, 0, 0, 32'h0));
        vecs.push_back(mk(1, 0, 0, 32'h40,       32'h1,        C_WORD, 0, 0, 0, 32'h0));
        vecs.push_back(mk(1, 0, 1, 32'h40,       32'h2,        C_WORD, 0, 0, 0, 32'h0));
        vecs.push_back(mk(0, 0, 1, 32'h0,        32'h0,        C_WORD, 0, 0, 0, 32'h0));
        vecs.push_back(mk(0, 0, 1, 32'h0,        32'h0,        C_WORD, 0, 0, 0, 32'h0));
        vecs.push_back(mk(1, 0, 0, 32'h50,       32'hBEEF,     C_HALF, 0, 0, 0, 32'h0));
        vecs.push_back(mk(0, 1, 0, 32'h50,       32'h0,        C_HALF, 1, 0, 0, 32'hBEEF));
        vecs.push_back(mk(0, 1, 0, 32'h52,       32'h0,        C_HALF, 0, 0, 1, 32'h0));
        vecs.push_back(mk(0, 1, 0, 32'h54,       32'h0,        C_WORD, 0, 1, 0, 32'h0));
        vecs.push_back(mk(0, 0, 1, 32'h0,        32'h0,        C_WORD, 0, 0, 0, 32'h0));

        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        rsn_i = 1'b1;
        #1;
        check("reset_valid", 32'(data_valid_o), 32'h0);
        check("reset_full", 32'(full_o), 32'h0);
        check("reset_type", 32'(memop_data_type_o), 32'h0);

        for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

        // Two entries live, then an asynchronous reset between clock edges.
        apply(mk(1, 0, 0, 32'h10, 32'h11, C_WORD, 0, 0, 0, 32'h0), 100);
        apply(mk(1, 0, 0, 32'h20, 32'h22, C_WORD, 0, 0, 0, 32'h0), 101);
        @(negedge clk_i);
        req_store_i = 1'b0; req_load_i = 1'b0; flush_chance_i = 1'b0;
        #1;
        check("pre_reset_full", 32'(full_o), 32'h1);
        rsn_i = 1'b0;
        #1;
        check("async_reset_valid", 32'(data_valid_o), 32'h0);
        check("async_reset_full", 32'(full_o), 32'h0);
        check("async_reset_addr", addr_o, 32'h0);
        sb.delete();
        @(posedge clk_i);
        #1;
        rsn_i = 1'b1;
        apply(mk(0, 1, 0, 32'h10, 32'h0, C_WORD, 0, 1, 0, 32'h0), 102);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
